// File: rtl/chi_req_tx_link.sv
// rtl/chi_req_tx_link.sv - CHI REQ transmit link: activation FSM, L-credit tracking and flit launch
module chi_req_tx_link #(
    parameter int FLIT_W  = 117,
    parameter int MAX_CRD = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              link_en,
    input  logic              in_valid,
    input  logic [FLIT_W-1:0] in_flit,
    output logic              in_ready,
    output logic              tx_link_active_req,
    input  logic              tx_link_active_ack,
    output logic              tx_req_flit_pend,
    output logic              tx_req_flitv,
    output logic [FLIT_W-1:0] tx_req_flit,
    input  logic              tx_req_lcrdv,
    output logic [3:0]        crd_cnt,
    output logic [1:0]        link_state,
    output logic              crd_err
);
    typedef enum logic [1:0] {
        ST_STOP       = 2'd0,
        ST_ACTIVATE   = 2'd1,
        ST_RUN        = 2'd2,
        ST_DEACTIVATE = 2'd3
    } state_t;

    localparam logic [3:0] CRD_MAX = 4'(MAX_CRD);

    state_t            r_state;
    logic [3:0]        r_crd;
    logic              r_err;
    logic              r_req;
    logic              r_flitv;
    logic [FLIT_W-1:0] r_flit;

    logic w_send_user;
    logic w_send_ret;
    logic w_launch;
    logic w_crd_ok;

    assign in_ready         = (r_state == ST_RUN) && (r_crd != 4'd0);
    assign w_send_user      = in_valid && in_ready;
    assign w_send_ret       = (r_state == ST_DEACTIVATE) && (r_crd != 4'd0);
    assign w_launch         = w_send_user || w_send_ret;
    assign w_crd_ok         = tx_req_lcrdv && (r_state != ST_STOP);
    assign tx_req_flit_pend = w_launch;

    assign tx_link_active_req = r_req;
    assign tx_req_flitv       = r_flitv;
    assign tx_req_flit        = r_flit;
    assign crd_cnt            = r_crd;
    assign link_state         = r_state;
    assign crd_err            = r_err;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_STOP;
            r_crd   <= 4'd0;
            r_err   <= 1'b0;
            r_req   <= 1'b0;
            r_flitv <= 1'b0;
            r_flit  <= '0;
        end else begin
            case (r_state)
                ST_STOP: begin
                    if (link_en) begin
                        r_state <= ST_ACTIVATE;
                        r_req   <= 1'b1;
                    end
                end
                ST_ACTIVATE: begin
                    if (tx_link_active_ack) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!link_en) begin
                        r_state <= ST_DEACTIVATE;
                        r_req   <= 1'b0;
                    end
                end
                default: begin
                    // A late credit arriving at zero must still be returned before STOP
                    if ((r_crd == 4'd0) && !tx_link_active_ack && !w_launch && !tx_req_lcrdv) begin
                        r_state <= ST_STOP;
                    end
                end
            endcase

            if (tx_req_lcrdv && (r_state == ST_STOP)) begin
                r_err <= 1'b1;
            end

            if (w_crd_ok && !w_launch) begin
                if (r_crd == CRD_MAX) begin
                    r_err <= 1'b1;
                end else begin
                    r_crd <= r_crd + 4'd1;
                end
            end else if (w_launch && !w_crd_ok) begin
                r_crd <= r_crd - 4'd1;
            end

            r_flitv <= w_launch;
            if (w_send_user) begin
                r_flit <= in_flit;
            end else if (w_send_ret) begin
                r_flit <= '0;
            end
        end
    end
endmodule

// File: tb/tb_chi_req_tx_link.sv
// tb/tb_chi_req_tx_link.sv - randomized and directed checking of chi_req_tx_link against a behavioural model
module tb_chi_req_tx_link;
    localparam int W    = 117;
    localparam int MAXC = 15;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         link_en = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_flit = '0;
    logic         ack = 1'b0;
    logic         lcrdv = 1'b0;
    logic         in_ready;
    logic         tx_link_active_req;
    logic         tx_req_flit_pend;
    logic         tx_req_flitv;
    logic [W-1:0] tx_req_flit;
    logic [3:0]   crd_cnt;
    logic [1:0]   link_state;
    logic         crd_err;

    chi_req_tx_link #(.FLIT_W(W), .MAX_CRD(MAXC)) dut (
        .clock              (clock),
        .reset              (reset),
        .link_en            (link_en),
        .in_valid           (in_valid),
        .in_flit            (in_flit),
        .in_ready           (in_ready),
        .tx_link_active_req (tx_link_active_req),
        .tx_link_active_ack (ack),
        .tx_req_flit_pend   (tx_req_flit_pend),
        .tx_req_flitv       (tx_req_flitv),
        .tx_req_flit        (tx_req_flit),
        .tx_req_lcrdv       (lcrdv),
        .crd_cnt            (crd_cnt),
        .link_state         (link_state),
        .crd_err            (crd_err)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    int           m_state;
    int           m_crd;
    bit           m_err;
    bit           m_req;
    bit           m_flitv;
    logic [W-1:0] m_flit;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_flit();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[W-1:0];
    endfunction

    task automatic model_clear();
        m_state = 0;
        m_crd   = 0;
        m_err   = 1'b0;
        m_req   = 1'b0;
        m_flitv = 1'b0;
        m_flit  = '0;
    endtask

    // Apply one cycle of inputs, compare every output against the model, then advance the model
    task automatic step(input logic le, input logic iv, input logic [W-1:0] fl,
                        input logic ak, input logic lc);
        bit rdy, user, send, ok;
        int ns, nc;
        @(negedge clock);
        link_en  = le;
        in_valid = iv;
        in_flit  = fl;
        ack      = ak;
        lcrdv    = lc;
        #1;
        rdy  = (m_state == 2) && (m_crd > 0);
        user = iv && rdy;
        send = user || ((m_state == 3) && (m_crd > 0));
        chk("in_ready", in_ready, rdy);
        chk("flit_pend", tx_req_flit_pend, send);
        chk("link_state", link_state, m_state[1:0]);
        chk("crd_cnt", crd_cnt, m_crd[3:0]);
        chk("crd_err", crd_err, m_err);
        chk("active_req", tx_link_active_req, m_req);
        chk("flitv", tx_req_flitv, m_flitv);
        chk("flit", tx_req_flit, m_flit);

        ok = lc && (m_state != 0);
        if (lc && m_state == 0) m_err = 1'b1;
        nc = m_crd;
        if (ok && !send) begin
            if (m_crd == MAXC) m_err = 1'b1;
            else nc = m_crd + 1;
        end else if (send && !ok) begin
            nc = m_crd - 1;
        end
        ns = m_state;
        case (m_state)
            0: if (le) ns = 1;
            1: if (ak) ns = 2;
            2: if (!le) ns = 3;
            default: if (m_crd == 0 && !ak && !lc) ns = 0;
        endcase
        if (user) m_flit = fl;
        else if (send) m_flit = '0;
        m_flitv = send;
        m_crd   = nc;
        m_state = ns;
        m_req   = (ns == 1) || (ns == 2);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_state", link_state, 2'd0);
        chk("rst_crd", crd_cnt, 4'd0);
        chk("rst_err", crd_err, 1'b0);
        chk("rst_req", tx_link_active_req, 1'b0);
        chk("rst_flitv", tx_req_flitv, 1'b0);
        chk("rst_flit", tx_req_flit, '0);
        chk("rst_ready", in_ready, 1'b0);
        chk("rst_pend", tx_req_flit_pend, 1'b0);
        link_en  = 1'b0;
        in_valid = 1'b0;
        ack      = 1'b0;
        lcrdv    = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        model_clear();
    endtask

    initial begin
        logic [W-1:0] fa, fb, fc, ff;
        logic         le, pk, lc;
        model_clear();
        do_reset();

        // Bring-up: ack after three ACTIVATE cycles, then four credits
        step(1, 0, '0, 0, 0);
        step(1, 0, '0, 0, 0);
        step(1, 0, '0, 0, 0);
        step(1, 0, '0, 0, 0);
        chk("bu_activate", link_state, 2'd1);
        step(1, 0, '0, 1, 1);
        step(1, 0, '0, 1, 1);
        step(1, 0, '0, 1, 1);
        step(1, 0, '0, 1, 1);
        step(1, 0, '0, 1, 0);
        chk("bu_state", link_state, 2'd2);
        chk("bu_crd", crd_cnt, 4'd4);
        chk("bu_ready", in_ready, 1'b1);

        // Back-to-back send with two credits left
        step(1, 1, rand_flit(), 1, 0);
        step(1, 1, rand_flit(), 1, 0);
        fa = rand_flit();
        fb = rand_flit();
        fc = rand_flit();
        step(1, 1, fa, 1, 0);
        chk("b2b_crd2", crd_cnt, 4'd2);
        step(1, 1, fb, 1, 0);
        chk("b2b_flitA", tx_req_flit, fa);
        step(1, 1, fc, 1, 0);
        chk("b2b_flitB", tx_req_flit, fb);
        chk("b2b_crd0", crd_cnt, 4'd0);
        chk("b2b_stall", in_ready, 1'b0);
        step(1, 0, '0, 1, 0);
        chk("b2b_idle", tx_req_flitv, 1'b0);

        // Simultaneous credit grant and send at one credit
        step(1, 0, '0, 1, 1);
        ff = rand_flit();
        step(1, 1, ff, 1, 1);
        chk("sim_pend", tx_req_flit_pend, 1'b1);
        step(1, 0, '0, 1, 0);
        chk("sim_crd", crd_cnt, 4'd1);
        chk("sim_flit", tx_req_flit, ff);
        chk("sim_flitv", tx_req_flitv, 1'b1);

        // Teardown with three credits held
        step(1, 0, '0, 1, 1);
        step(1, 0, '0, 1, 1);
        step(0, 0, '0, 1, 0);
        chk("td_crd3", crd_cnt, 4'd3);
        step(0, 0, '0, 0, 0);
        chk("td_state", link_state, 2'd3);
        chk("td_req", tx_link_active_req, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, '0, 0, 0);
            chk("td_flitv", tx_req_flitv, 1'b1);
            chk("td_zero", tx_req_flit, '0);
        end
        chk("td_crd0", crd_cnt, 4'd0);
        step(0, 0, '0, 0, 0);
        chk("td_stop", link_state, 2'd0);

        // Credit in STOP, then credit overflow in RUN
        step(0, 0, '0, 0, 1);
        step(0, 0, '0, 0, 0);
        chk("stop_err", crd_err, 1'b1);
        chk("stop_crd", crd_cnt, 4'd0);
        do_reset();
        step(1, 0, '0, 0, 0);
        step(1, 0, '0, 1, 0);
        for (int i = 0; i < 16; i++) step(1, 0, '0, 1, 1);
        step(1, 0, '0, 1, 0);
        chk("ovf_crd", crd_cnt, 4'd15);
        chk("ovf_err", crd_err, 1'b1);

        // Asynchronous reset mid-RUN with five credits and a flit on the wire
        do_reset();
        step(1, 0, '0, 0, 0);
        step(1, 0, '0, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 0, '0, 1, 1);
        step(1, 1, rand_flit(), 1, 1);
        step(1, 0, '0, 1, 0);
        chk("ar_crd5", crd_cnt, 4'd5);
        chk("ar_flitv", tx_req_flitv, 1'b1);
        #1;
        do_reset();
        for (int i = 0; i < 5; i++) step(0, 0, '0, 0, 0);

        // Randomized traffic with a responsive link partner
        le = 1'b1;
        pk = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) le = ~le;
            if (tx_link_active_req && !pk && $urandom_range(0, 3) == 0) pk = 1'b1;
            else if (!tx_link_active_req && pk && $urandom_range(0, 2) == 0) pk = 1'b0;
            lc = (link_state != 2'd0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 599) == 0) begin
                #1;
                do_reset();
                pk = 1'b0;
            end
            step(le, 1'($urandom_range(0, 1)), rand_flit(), pk, lc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/chi_req_tx_link.md
CHI_REQ_TX_LINK -- requirements
Module: chi_req_tx_link

Interface
REQ-001 SHALL have parameter FLIT_W, default 117, meaning REQ flit width.
REQ-002 SHALL have parameter MAX_CRD, default 15, meaning maximum held L-credits (1..15).
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port link_en  input  1  1 = bring link up, 0 = take link down.
REQ-006 SHALL have port in_valid  input  1  upstream flit valid.
REQ-007 SHALL have port in_flit  input  FLIT_W  upstream flit payload.
REQ-008 SHALL have port in_ready  output  1  upstream flit accepted this cycle when in_valid=1.
REQ-009 SHALL have port tx_link_active_req  output  1  CHI TX LinkActiveReq.
REQ-010 SHALL have port tx_link_active_ack  input  1  CHI TX LinkActiveAck.
REQ-011 SHALL have port tx_req_flit_pend  output  1  flit pending, one cycle ahead of flitv.
REQ-012 SHALL have port tx_req_flitv  output  1  flit valid.
REQ-013 SHALL have port tx_req_flit  output  FLIT_W  flit payload.
REQ-014 SHALL have port tx_req_lcrdv  input  1  one L-credit granted per asserted cycle.
REQ-015 SHALL have port crd_cnt  output  4  current held credit count.
REQ-016 SHALL have port link_state  output  2  STOP=0, ACTIVATE=1, RUN=2, DEACTIVATE=3.
REQ-017 SHALL have port crd_err  output  1  sticky credit-protocol error.

Function
REQ-018 SHALL implement FSM: STOP -> ACTIVATE when link_en=1; ACTIVATE -> RUN when tx_link_active_ack=1; RUN -> DEACTIVATE when link_en=0; DEACTIVATE -> STOP when crd_cnt=0 and tx_link_active_ack=0 and no flit pending.
REQ-019 SHALL drive tx_link_active_req registered: 1 in ACTIVATE and RUN, 0 in STOP and DEACTIVATE.
REQ-020 SHALL count credits: +1 on tx_req_lcrdv, -1 per flit sent; both in same cycle -> unchanged.
REQ-021 SHALL accept tx_req_lcrdv in ACTIVATE, RUN, DEACTIVATE; lcrdv in STOP is ignored and sets crd_err.
REQ-022 SHALL saturate crd_cnt at MAX_CRD; lcrdv at MAX_CRD without same-cycle send sets crd_err.
REQ-023 SHALL drive in_ready combinationally = (link_state==RUN) and (crd_cnt!=0); no skid buffering.
REQ-024 SHALL, on in_valid and in_ready, register in_flit to tx_req_flit and assert tx_req_flitv next cycle (latency 1).
REQ-025 SHALL drive tx_req_flit_pend combinationally = 1 exactly in cycles where a flit is launched (next-cycle flitv=1).
REQ-026 SHALL, in DEACTIVATE with crd_cnt!=0, send one LCrdReturn flit per cycle: all-zero payload, flitv=1, consuming one credit.
REQ-027 SHALL return credits granted during DEACTIVATE the same way until crd_cnt=0.
REQ-028 SHALL hold tx_req_flitv=0 and tx_req_flit unchanged in cycles with no launch.
REQ-029 SHALL, if link_en returns to 1 during DEACTIVATE, complete deactivation to STOP before re-entering ACTIVATE.
REQ-030 SHALL ignore link_en=0 in ACTIVATE until RUN is reached (no abort of handshake).
REQ-031 SHALL clear crd_err only by reset.

Reset
REQ-032 SHALL, on reset assertion, immediately force link_state=STOP, crd_cnt=0, crd_err=0, tx_link_active_req=0, tx_req_flitv=0, tx_req_flit=0; in_ready and tx_req_flit_pend thereby 0.
REQ-033 SHALL discard in-flight flits and held credits on reset mid-operation; no credit return is sent.
REQ-034 SHALL leave STOP only on the first rising edge after reset deassertion with link_en=1.

Verification
REQ-035 SHALL cover bring-up: link_en=1, ack after 3 cycles, 4 lcrdv pulses -> state 0->1->2, crd_cnt=4, in_ready=1.
REQ-036 SHALL cover back-to-back send: crd_cnt=2, in_valid held 3 cycles with flits A,B,C -> A,B on tx_req_flit in consecutive cycles, C stalled, crd_cnt=0, in_ready=0.
REQ-037 SHALL cover simultaneous lcrdv and send at crd_cnt=1 -> crd_cnt stays 1, flit issued next cycle.
REQ-038 SHALL cover teardown: crd_cnt=3, link_en=0 -> tx_link_active_req=0, three all-zero flits on 3 consecutive cycles, crd_cnt=0, STOP after ack drops.
REQ-039 SHALL cover errors: lcrdv in STOP -> crd_err=1, crd_cnt=0; 16 lcrdv in RUN with MAX_CRD=15 -> crd_cnt=15, crd_err=1.
REQ-040 SHALL cover async reset mid-RUN with crd_cnt=5 and flitv=1 -> all outputs 0 before next clock edge, no LCrdReturn flits.
